// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg -- one-stage pipeline register with an optional skid entry.
//
// Registers a valid/ready stream with exactly one cycle of latency. With
// SKID=1 a second holding entry lets in_ready come straight from a flop, so
// the ready path is cut. With SKID=0 there is a single entry, and in_ready
// is combinational from out_ready.
//
// Ports
//   clk        single clock, rising edge
//   reset      synchronous active-high reset
//   flush      synchronous discard of all held entries
//   in_valid   upstream payload valid
//   in_ready   block can accept a payload this cycle
//   in_data    upstream payload [DATA_W]
//   out_valid  out_data holds a valid payload
//   out_ready  downstream accepts this cycle
//   out_data   head payload [DATA_W], straight from a register
//   occupancy  held entries: 0, 1 or 2
module pipe_skid_reg #(
  parameter int                DATA_W     = 32,
  parameter int                SKID       = 1,
  parameter logic [DATA_W-1:0] RESET_DATA = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  // The encoding equals the entry count, so occupancy is the state itself.
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] main_q, skid_q, main_nxt;
  logic              main_ld, skid_ld;
  logic              in_fire, out_fire;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign out_data = main_q;

  // State and payload registers. Payloads only load on their enables, so
  // they stay quiet whenever data is not moving. Flush leaves skid_q alone:
  // it cannot be observed until a fresh load overwrites it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      main_q  <= RESET_DATA;
      skid_q  <= RESET_DATA;
    end else if (flush) begin
      state_q <= EMPTY;
      main_q  <= RESET_DATA;
    end else begin
      state_q <= state_d;
      if (main_ld) main_q <= main_nxt;
      if (skid_ld) skid_q <= in_data;
    end
  end

  // Next state and load enables. With SKID=0, in_ready in ONE equals
  // out_ready, so an input transfer there always comes with an output
  // transfer. FULL is therefore unreachable in that mode.
  always_comb begin
    state_d  = state_q;
    main_ld  = 1'b0;
    skid_ld  = 1'b0;
    main_nxt = in_data;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          state_d = ONE;
          main_ld = 1'b1;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          main_ld = 1'b1;
        end else if (in_fire) begin
          state_d = FULL;
          skid_ld = 1'b1;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          state_d  = ONE;
          main_ld  = 1'b1;
          main_nxt = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Outputs. With SKID=1, in_ready depends on registered state only. flush
  // has no path to in_ready in either mode.
  always_comb begin
    out_valid = (state_q != EMPTY);
    occupancy = state_q;
    if (SKID != 0) in_ready = (state_q != FULL);
    else           in_ready = (state_q == EMPTY) || out_ready;
  end

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, payload width in bits (1..256).
REQ-002 The block SHALL have parameter SKID, default 1: 1 = two-entry skid mode (registered in_ready); 0 = single-entry mode (combinational in_ready).
REQ-003 The block SHALL have parameter RESET_DATA, default 0 (DATA_W bits), the value loaded into out_data on reset and flush.
REQ-004 The block SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 The block SHALL have port flush, input, 1, synchronous discard of all held entries.
REQ-007 The block SHALL have port in_valid, input, 1, upstream holds a valid payload.
REQ-008 The block SHALL have port in_ready, output, 1, block can accept a payload this cycle.
REQ-009 The block SHALL have port in_data, input, DATA_W, upstream payload.
REQ-010 The block SHALL have port out_valid, output, 1, out_data holds a valid payload.
REQ-011 The block SHALL have port out_ready, input, 1, downstream accepts this cycle.
REQ-012 The block SHALL have port out_data, output, DATA_W, head payload, driven directly from a register.
REQ-013 The block SHALL have port occupancy, output, 2, number of held entries (0, 1 or 2).

Function
REQ-014 The block SHALL define an input transfer as in_valid && in_ready and an output transfer as out_valid && out_ready, each sampled at the rising clk edge.
REQ-015 The block SHALL deliver payloads in acceptance order with no loss or duplication, except payloads discarded by flush or reset.
REQ-016 The block SHALL have a latency of exactly 1 cycle: a payload accepted at edge N appears on out_data with out_valid=1 after edge N if the block was empty.
REQ-017 With SKID=1, the block SHALL implement states EMPTY, ONE and FULL, with occupancy equal to 0, 1 and 2 respectively.
REQ-018 With SKID=1, in_ready SHALL equal (state != FULL) and SHALL depend on registered state only.
REQ-019 EMPTY: on an input transfer, the block SHALL move to ONE with main=in_data; otherwise it SHALL hold.
REQ-020 ONE: on simultaneous input and output transfers, the block SHALL stay in ONE with main=in_data.
REQ-021 ONE: on an input transfer alone, the block SHALL move to FULL with skid=in_data and main unchanged.
REQ-022 ONE: on an output transfer alone, the block SHALL move to EMPTY.
REQ-023 FULL: on an output transfer, the block SHALL move to ONE with main=skid; otherwise it SHALL hold. No input transfer is possible in FULL.
REQ-024 With SKID=0, the block SHALL implement states EMPTY and ONE only, with in_ready = !out_valid || out_ready (combinational); a simultaneous input and output transfer SHALL reload main.
REQ-025 out_valid SHALL be 1 in ONE and FULL, and 0 in EMPTY.
REQ-026 On a move to EMPTY, out_data SHALL hold its last value.
REQ-027 When flush=1 and reset=0, the block SHALL, at the next edge, go to EMPTY with out_data=RESET_DATA and occupancy=0.
REQ-028 Any input or output transfer occurring in a flush cycle SHALL be ignored: the input payload is dropped and never emitted.
REQ-029 In a flush cycle, in_ready SHALL still follow REQ-018/REQ-024, with no combinational path from flush to in_ready.
REQ-030 Priority SHALL be reset > flush > handshake.
REQ-031 Payload registers SHALL capture only on their load conditions; no payload register SHALL toggle otherwise.

Reset
REQ-032 When reset=1 at a rising edge, the block SHALL set state=EMPTY, out_valid=0, out_data=RESET_DATA, occupancy=0 and skid=RESET_DATA, regardless of flush or the handshakes.
REQ-033 After reset, in_ready SHALL be 1 in both modes.
REQ-034 Reset asserted in any state, including FULL, SHALL discard all entries, with no payload emitted afterward.

Verification
REQ-035 Reset: the bench SHALL assert reset for 2 cycles with in_valid=1 and in_data=0x55 -> out_valid=0, out_data=0x0, occupancy=0, in_ready=1, and 0x55 never emitted.
REQ-036 Streaming (SKID=1): the bench SHALL hold out_ready=1 and send 0x1, 0x2, 0x3 on consecutive cycles -> out_data 0x1, 0x2, 0x3 on the following three cycles with occupancy=1 throughout and in_ready=1.
REQ-037 Backpressure (SKID=1): the bench SHALL hold out_ready=0 and send 0xA, 0xB -> occupancy=2 and in_ready=0; 0xC is held upstream; then release out_ready=1 -> outputs 0xA, 0xB, 0xC in order with in_ready back to 1 one cycle after the first pop.
REQ-038 Flush in FULL: the bench SHALL, with entries 0xA and 0xB held, pulse flush for 1 cycle while offering 0xC with out_ready=1 -> next cycle out_valid=0, occupancy=0, out_data=RESET_DATA, and 0xA, 0xB, 0xC never observed.
REQ-039 SKID=0: the bench SHALL set out_valid=1 and out_ready=0 -> in_ready=0 in the same cycle; then set out_ready=1 and in_valid=1 with 0x7 -> in_ready=1 in the same cycle, with 0x7 on out_data next cycle and occupancy staying at 1.
REQ-040 Simultaneous flush and reset: the bench SHALL assert both in FULL -> reset values per REQ-032, followed by normal acceptance in the next cycle.
